// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader and its RAM.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } imem_state_e;

  localparam logic [5:0]  OP_HALT   = 6'b111111;
  localparam logic [31:0] HALT_WORD = {OP_HALT, 26'h0};
  localparam logic [31:0] NOP_WORD  = 32'h0;

  // True when a word address lies beyond a RAM of 2**addr_w words.
  function automatic logic is_out_of_range(input logic [31:0] addr, input int addr_w);
    return (addr >> addr_w) != 32'h0;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port instruction RAM: synchronous write port for the loader,
// synchronous read port for fetch. Contents are never cleared.
module imem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory front end: streams a program into the RAM in load mode,
// then releases the core and serves fetch reads (HALT beyond the RAM).
//
// Write stream: a word transfers on a rising edge where wr_valid and wr_ready
// are both high; wr_ready is registered and depends only on state, never on
// wr_valid, and wr_data/wr_last are sampled only on that transfer edge.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              core_run,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output imem_state_e       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              core_run_q, core_run_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              fetch_from_ram_q, fetch_from_ram_d;
  logic [31:0]       fetch_hold_q, fetch_hold_d;

  logic              accept;
  logic              fetch_oor;
  logic              run_fetch;
  logic              ram_rd_en;
  logic [31:0]       ram_rd_data;

  assign accept    = wr_valid & wr_ready_q;
  assign fetch_oor = is_out_of_range(fetch_addr, ADDR_W);
  // A load request in RUN takes priority over a same-cycle fetch.
  assign run_fetch = (state_q == RUN) && !load_req;
  assign ram_rd_en = run_fetch && fetch_en && !fetch_oor;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    load_done_d  = 1'b0;

    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (load_req) begin
          state_d      = LOAD;
          ptr_d        = load_base;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          ptr_d        = ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (wr_last) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end else if (ptr_q == LAST_ADDR) begin
            // Last slot filled without end-of-program: stop rather than wrap.
            state_d    = ERR;
            load_err_d = 1'b1;
          end
        end
      end
    endcase

    wr_ready_d = (state_d == LOAD);
    core_run_d = (state_d == RUN);
  end

  always_comb begin
    fetch_from_ram_d = fetch_from_ram_q;
    fetch_hold_d     = fetch_hold_q;
    if (!run_fetch) begin
      fetch_from_ram_d = 1'b0;
      fetch_hold_d     = NOP_WORD;
    end else if (fetch_en) begin
      fetch_from_ram_d = !fetch_oor;
      fetch_hold_d     = fetch_oor ? HALT_WORD : fetch_hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      load_count_q     <= '0;
      wr_ready_q       <= 1'b0;
      core_run_q       <= 1'b0;
      load_done_q      <= 1'b0;
      load_err_q       <= 1'b0;
      fetch_from_ram_q <= 1'b0;
      fetch_hold_q     <= NOP_WORD;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      load_count_q     <= load_count_d;
      wr_ready_q       <= wr_ready_d;
      core_run_q       <= core_run_d;
      load_done_q      <= load_done_d;
      load_err_q       <= load_err_d;
      fetch_from_ram_q <= fetch_from_ram_d;
      fetch_hold_q     <= fetch_hold_d;
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (ptr_q),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (fetch_addr[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // Both sources are registered; the select only picks which register drives.
  assign fetch_instr = fetch_from_ram_q ? ram_rd_data : fetch_hold_q;
  assign wr_ready    = wr_ready_q;
  assign core_run    = core_run_q;
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign load_err    = load_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: fetch results go through an expected queue
// checked by a monitor; status outputs are checked inline.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [9:0]  load_base;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        core_run;
  logic        load_done;
  logic [10:0] load_count;
  logic        load_err;
  imem_state_e dbg_state;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        fetch_fired = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .load_base   (load_base),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .core_run    (core_run),
    .load_done   (load_done),
    .load_count  (load_count),
    .load_err    (load_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(posedge clk) fetch_fired <= fetch_en;

  always @(negedge clk) begin
    if (load_done) done_cnt <= done_cnt + 1;
    if (fetch_fired) begin
      if (exp_q.size() == 0) begin
        check("fetch_unexpected", fetch_instr, 32'h0);
      end else begin
        check(name_q.pop_front(), fetch_instr, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic load_start(input logic [9:0] base);
    load_req  = 1'b1;
    load_base = base;
    tick();
    load_req  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int budget = 8;
    while (!wr_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!wr_ready) check("wr_ready_timeout", {31'h0, wr_ready}, 32'h1);
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic run,
                              input logic err, input logic [10:0] cnt);
    check({tag, "_wr_ready"}, {31'h0, wr_ready}, {31'h0, rdy});
    check({tag, "_core_run"}, {31'h0, core_run}, {31'h0, run});
    check({tag, "_load_err"}, {31'h0, load_err}, {31'h0, err});
    check({tag, "_load_count"}, {21'h0, load_count}, {21'h0, cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int done_before;
    logic [31:0] prog [4];
    prog[0] = 32'h00221000;
    prog[1] = 32'h10420005;
    prog[2] = 32'h00000000;
    prog[3] = 32'hFC000000;

    rst = 1'b1; load_req = 1'b0; load_base = '0; wr_valid = 1'b0;
    wr_data = '0; wr_last = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    repeat (2) tick();
    check_status("reset", 1'b0, 1'b0, 1'b0, 11'd0);
    check("reset_load_done", {31'h0, load_done}, 32'h0);
    check("reset_fetch_instr", fetch_instr, 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // basic 4-word program from base 0
    load_start(10'h000);
    check_status("load_entry", 1'b1, 1'b0, 1'b0, 11'd0);
    done_before = done_cnt;
    for (int i = 0; i < 4; i++) send_word(prog[i], i == 3);
    check("prog_done_pulse", {31'h0, load_done}, 32'h1);
    check_status("prog_end", 1'b0, 1'b1, 1'b0, 11'd4);
    tick();
    check("prog_done_low", {31'h0, load_done}, 32'h0);
    check("prog_done_once", 32'(done_cnt - done_before), 32'd1);
    for (int i = 0; i < 4; i++) fetch(32'(i), prog[i], "prog_fetch");

    // load request colliding with a fetch in RUN
    load_req = 1'b1; load_base = 10'h3F0;
    fetch_en = 1'b1; fetch_addr = 32'd1;
    exp_q.push_back(32'h0); name_q.push_back("collide_fetch");
    tick();
    load_req = 1'b0; fetch_en = 1'b0;
    check_status("collide", 1'b1, 1'b0, 1'b0, 11'd0);

    // gapped stream at base 0x3F0
    wr_data = 32'h11111111; wr_valid = 1'b1; tick();
    wr_valid = 1'b0; wr_data = 32'hDEADBEEF; tick();
    check("gap_count1", {21'h0, load_count}, 32'd1);
    wr_data = 32'h22222222; wr_valid = 1'b1; tick();
    wr_valid = 1'b0; wr_data = 32'hDEADBEEF; tick();
    check("gap_count2", {21'h0, load_count}, 32'd2);
    wr_data = 32'h33333333; wr_last = 1'b1; wr_valid = 1'b1; tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    check_status("gap_end", 1'b0, 1'b1, 1'b0, 11'd3);
    fetch(32'h3F0, 32'h11111111, "gap_fetch0");
    fetch(32'h3F1, 32'h22222222, "gap_fetch1");
    fetch(32'h3F2, 32'h33333333, "gap_fetch2");
    fetch(32'h0, prog[0], "old_word_kept");
    fetch(32'd1024, HALT_WORD, "halt_1024");
    tick();
    check("halt_hold", fetch_instr, HALT_WORD);
    fetch(32'hFFFFFFFF, HALT_WORD, "halt_max");
    fetch(32'd1, prog[1], "after_halt");

    // overflow at the top of the RAM
    load_start(10'h3FE);
    send_word(32'hAAAA0001, 1'b0);
    send_word(32'hAAAA0002, 1'b0);
    check_status("ovf", 1'b0, 1'b0, 1'b1, 11'd2);
    check("ovf_state", 32'(dbg_state), 32'(ERR));
    wr_valid = 1'b1; wr_data = 32'hAAAA0003; tick();
    wr_valid = 1'b0;
    check("ovf_no_accept", {21'h0, load_count}, 32'd2);
    fetch(32'd5, 32'h0, "err_fetch");
    load_start(10'h100);
    check_status("reload", 1'b1, 1'b0, 1'b0, 11'd0);
    send_word(32'h0000BEEF, 1'b1);
    fetch(32'h3FE, 32'hAAAA0001, "ovf_word0");
    fetch(32'h3FF, 32'hAAAA0002, "ovf_word1");
    fetch(32'h100, 32'h0000BEEF, "reload_word");

    // exact fit ending on the last slot
    load_start(10'h3FE);
    send_word(32'hB0000001, 1'b0);
    send_word(32'hB0000002, 1'b1);
    check_status("exact", 1'b0, 1'b1, 1'b0, 11'd2);
    fetch(32'h3FF, 32'hB0000002, "exact_fetch");

    // async reset in the middle of a load
    load_start(10'h200);
    send_word(32'hC0000001, 1'b0);
    send_word(32'hC0000002, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 11'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_fetch_instr", fetch_instr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    load_start(10'h300);
    send_word(32'hD0000001, 1'b1);
    fetch(32'h200, 32'hC0000001, "rst_kept0");
    fetch(32'h201, 32'hC0000002, "rst_kept1");
    fetch(32'h300, 32'hD0000001, "post_rst_load");

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
